// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 32
);
   // Instruction fetch requester
   logic            i_req;
   logic [AW-1:0]   i_addr;
   logic            i_ack;
   logic [DW-1:0]   i_rdata;

   // Load/store requester
   logic            d_req;
   logic            d_we;
   logic [DW/8-1:0] d_be;
   logic [AW-1:0]   d_addr;
   logic [DW-1:0]   d_wdata;
   logic            d_ack;
   logic [DW-1:0]   d_rdata;

   // Single-ported word-addressed memory, synchronous read
   logic            mem_en;
   logic            mem_we;
   logic [DW/8-1:0] mem_be;
   logic [AW-3:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   // Arbiter view
   modport slave (
      input  i_req, i_addr,
      output i_ack, i_rdata,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output d_ack, d_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Environment view: requesters plus memory
   modport master (
      output i_req, i_addr,
      input  i_ack, i_rdata,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  d_ack, d_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/load-store arbiter for a single-ported unified memory
module mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus,
   output logic         busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE_I,
      S_ISSUE_D,
      S_RESP_I,
      S_RESP_D
   } state_t;

   state_t state, state_nx;

   // 1 when the data side won the most recent grant, 0 when fetch did
   logic last_d;

   logic cand_i, cand_d;
   logic grant_i, grant_d;

   // Registered memory-side command, non-zero only during an ISSUE cycle
   logic            mem_en_q;
   logic            mem_we_q;
   logic [DW/8-1:0] mem_be_q;
   logic [AW-3:0]   mem_addr_q;
   logic [DW-1:0]   mem_wdata_q;

   // Remembers whether the in-flight data access is a store, so its ack returns zero data
   logic            d_we_q;

   // Last returned read data, held between acks
   logic [DW-1:0]   i_rdata_q;
   logic [DW-1:0]   d_rdata_q;

   logic [DW-1:0]   d_resp_data;

   // Byte-offset bits of both addresses are ignored for a word-addressed memory
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Candidate selection, round-robin grant and next-state decode
   always_comb begin
      state_nx = state;
      cand_i   = 1'b0;
      cand_d   = 1'b0;
      grant_i  = 1'b0;
      grant_d  = 1'b0;

      // The requester being acked this cycle cannot be re-granted back-to-back
      case (state)
         S_IDLE: begin
            cand_i = bus.i_req;
            cand_d = bus.d_req;
         end
         S_RESP_I: cand_d = bus.d_req;
         S_RESP_D: cand_i = bus.i_req;
         default: ;
      endcase

      if (cand_i && cand_d) begin
         grant_i = last_d;
         grant_d = !last_d;
      end else begin
         grant_i = cand_i;
         grant_d = cand_d;
      end

      case (state)
         S_ISSUE_I: state_nx = S_RESP_I;
         S_ISSUE_D: state_nx = S_RESP_D;
         default: begin
            if (grant_i) begin
               state_nx = S_ISSUE_I;
            end else if (grant_d) begin
               state_nx = S_ISSUE_D;
            end else begin
               state_nx = S_IDLE;
            end
         end
      endcase
   end

   // Round-robin pointer follows every grant
   always_ff @(posedge clk) begin
      if (rst) begin
         last_d <= 1'b0;
      end else if (grant_i) begin
         last_d <= 1'b0;
      end else if (grant_d) begin
         last_d <= 1'b1;
      end
   end

   // Capture the granted request into the memory command registers; clear them otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else if (grant_i) begin
         mem_en_q    <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '1;
         mem_addr_q  <= bus.i_addr[AW-1:2];
         mem_wdata_q <= '0;
      end else if (grant_d) begin
         mem_en_q    <= 1'b1;
         mem_we_q    <= bus.d_we;
         mem_be_q    <= bus.d_be;
         mem_addr_q  <= bus.d_addr[AW-1:2];
         mem_wdata_q <= bus.d_wdata;
      end else begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end
   end

   // Store/load flag of the data access, kept until its response cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         d_we_q <= 1'b0;
      end else if (grant_d) begin
         d_we_q <= bus.d_we;
      end
   end

   assign d_resp_data = d_we_q ? '0 : bus.mem_rdata;

   // Hold the most recently returned data so rdata stays stable between acks
   always_ff @(posedge clk) begin
      if (rst) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (state == S_RESP_I) begin
            i_rdata_q <= bus.mem_rdata;
         end
         if (state == S_RESP_D) begin
            d_rdata_q <= d_resp_data;
         end
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   assign bus.i_ack   = (state == S_RESP_I);
   assign bus.d_ack   = (state == S_RESP_D);
   assign bus.i_rdata = (state == S_RESP_I) ? bus.mem_rdata : i_rdata_q;
   assign bus.d_rdata = (state == S_RESP_D) ? d_resp_data   : d_rdata_q;

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with memory and requester models
module tb_mem_arbiter;

   logic clk;
   logic rst;
   logic busy;
   logic mem_init;

   mem_arbiter_if #(.AW(8), .DW(32)) bif ();

   mem_arbiter #(.AW(8), .DW(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bif),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int n_cmp;
   int n_err;
   int cyc;

   logic [31:0] mem    [64];
   logic [31:0] shadow [64];

   int i_start, d_start, i_bound, d_bound, i_gap, d_gap;

   logic        bus_pend;
   logic [5:0]  bus_addr;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        prev_i_ack, prev_d_ack;

   function automatic logic [31:0] init_word(input int k);
      return 32'hDEADBEEF ^ (32'(k ^ 5) * 32'h0001_0203);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      end
      return r;
   endfunction

   // Synchronous-read memory with byte-enable writes
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
      end else if (bif.mem_en) begin
         if (bif.mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (bif.mem_be[b]) mem[bif.mem_addr][8*b +: 8] <= bif.mem_wdata[8*b +: 8];
            end
         end
         bif.mem_rdata <= mem[bif.mem_addr];
      end
   end

   // Requests may only fall in the cycle they are acknowledged
   assert property (@(posedge clk) disable iff (rst) $fell(bif.i_req) |-> bif.i_ack)
      else $error("protocol: i_req dropped before i_ack");
   assert property (@(posedge clk) disable iff (rst) $fell(bif.d_req) |-> bif.d_ack)
      else $error("protocol: d_req dropped before d_ack");

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic new_i();
      bif.i_req  = 1'b1;
      bif.i_addr = 8'($urandom);
      i_start    = cyc;
   endtask

   task automatic new_d();
      bif.d_req   = 1'b1;
      bif.d_we    = 1'($urandom);
      bif.d_be    = 4'($urandom);
      bif.d_addr  = 8'($urandom);
      bif.d_wdata = $urandom;
      d_start     = cyc;
   endtask

   task automatic i_done();
      chk("i_rdata", 64'(bif.i_rdata), 64'(shadow[bif.i_addr[7:2]]));
   endtask

   task automatic d_done();
      if (bif.d_we) begin
         chk("d_rdata_store", 64'(bif.d_rdata), 64'(0));
         shadow[bif.d_addr[7:2]] = merge(shadow[bif.d_addr[7:2]], bif.d_wdata, bif.d_be);
      end else begin
         chk("d_rdata_load", 64'(bif.d_rdata), 64'(shadow[bif.d_addr[7:2]]));
      end
   endtask

   initial begin
      logic [31:0] exp6;
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      clk = 1'b0;
      rst = 1'b1;
      mem_init = 1'b1;
      bif.i_req = 1'b0; bif.i_addr = '0;
      bif.d_req = 1'b0; bif.d_we = 1'b0; bif.d_be = '0; bif.d_addr = '0; bif.d_wdata = '0;
      for (int k = 0; k < 64; k++) shadow[k] = init_word(k);
      tick();
      mem_init = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_acks", 64'({bif.i_ack, bif.d_ack}), 64'(0));
      chk("rst_rdata", 64'({bif.i_rdata, bif.d_rdata}), 64'(0));
      chk("rst_mem", 64'({bif.mem_en, bif.mem_we, bif.mem_be, bif.mem_addr, bif.mem_wdata}), 64'(0));
      rst = 1'b0;

      // Single fetch from idle
      bif.i_req = 1'b1; bif.i_addr = 8'h14;
      tick();
      chk("t1_mem_en", 64'(bif.mem_en), 64'(1));
      chk("t1_mem_addr", 64'(bif.mem_addr), 64'(6'h05));
      chk("t1_mem_we", 64'(bif.mem_we), 64'(0));
      chk("t1_mem_be", 64'(bif.mem_be), 64'(4'hF));
      chk("t1_early_ack", 64'(bif.i_ack), 64'(0));
      tick();
      chk("t1_i_ack", 64'(bif.i_ack), 64'(1));
      chk("t1_i_rdata", 64'(bif.i_rdata), 64'(32'hDEADBEEF));
      bif.i_req = 1'b0;
      tick();
      chk("t1_busy", 64'(busy), 64'(0));
      chk("t1_ack_pulse", 64'(bif.i_ack), 64'(0));
      chk("t1_rdata_hold", 64'(bif.i_rdata), 64'(32'hDEADBEEF));

      // Single store
      bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_be = 4'b0011;
      bif.d_addr = 8'h22; bif.d_wdata = 32'h1234_5678;
      tick();
      chk("t2_mem_we", 64'(bif.mem_we), 64'(1));
      chk("t2_mem_be", 64'(bif.mem_be), 64'(4'b0011));
      chk("t2_mem_addr", 64'(bif.mem_addr), 64'(6'h08));
      chk("t2_mem_wdata", 64'(bif.mem_wdata), 64'(32'h1234_5678));
      tick();
      chk("t2_d_ack", 64'(bif.d_ack), 64'(1));
      d_done();
      bif.d_req = 1'b0;
      tick();
      chk("t2_idle_mem", 64'({bif.mem_en, bif.mem_we, bif.mem_be, bif.mem_addr, bif.mem_wdata}), 64'(0));

      // Tie right after reset: data side first, fetch follows back-to-back
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      bif.i_req = 1'b1; bif.i_addr = 8'h20;
      bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_be = 4'hF; bif.d_addr = 8'h14;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("t3_d_ack", 64'(bif.d_ack), 64'(k == 2));
         chk("t3_i_ack", 64'(bif.i_ack), 64'(k == 4));
         if (k == 1) chk("t3_first_addr", 64'(bif.mem_addr), 64'(6'h05));
         if (k == 3) chk("t3_second_addr", 64'(bif.mem_addr), 64'(6'h08));
         if (bif.d_ack) begin d_done(); bif.d_req = 1'b0; end
         if (bif.i_ack) begin i_done(); bif.i_req = 1'b0; end
      end

      // Both requesters saturating: strict D,I alternation, one ack every two cycles
      new_i();
      new_d();
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("t4_d_ack", 64'(bif.d_ack), 64'(k % 4 == 2));
         chk("t4_i_ack", 64'(bif.i_ack), 64'(k % 4 == 0));
         if (bif.d_ack) begin
            d_done();
            if (k < 18) new_d(); else bif.d_req = 1'b0;
         end
         if (bif.i_ack) begin
            i_done();
            if (k < 20) new_i(); else bif.i_req = 1'b0;
         end
      end
      tick();

      // Reset while a fetch is on the memory bus
      bif.i_req = 1'b1; bif.i_addr = 8'h30;
      tick();
      chk("t5_issue", 64'(bif.mem_en), 64'(1));
      rst = 1'b1;
      tick();
      chk("t5_no_ack", 64'({bif.i_ack, bif.d_ack}), 64'(0));
      chk("t5_busy", 64'(busy), 64'(0));
      chk("t5_mem", 64'({bif.mem_en, bif.mem_we, bif.mem_be, bif.mem_addr, bif.mem_wdata}), 64'(0));
      chk("t5_rdata", 64'({bif.i_rdata, bif.d_rdata}), 64'(0));
      rst = 1'b0;
      tick();
      chk("t5_reissue", 64'(bif.mem_en), 64'(1));
      chk("t5_ack_wait", 64'(bif.i_ack), 64'(0));
      tick();
      chk("t5_ack", 64'(bif.i_ack), 64'(1));
      i_done();
      bif.i_req = 1'b0;
      tick();

      // Partial store then load of the same word
      exp6 = (init_word(16) & 32'hFF00_FF00) | (32'hA5C3_1E77 & 32'h00FF_00FF);
      bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_be = 4'b0101;
      bif.d_addr = 8'h40; bif.d_wdata = 32'hA5C3_1E77;
      tick();
      tick();
      chk("t6_store_ack", 64'(bif.d_ack), 64'(1));
      d_done();
      bif.d_req = 1'b0;
      tick();
      bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_be = 4'hF; bif.d_addr = 8'h40;
      tick();
      tick();
      chk("t6_load_ack", 64'(bif.d_ack), 64'(1));
      chk("t6_load_data", 64'(bif.d_rdata), 64'(exp6));
      d_done();
      bif.d_req = 1'b0;
      tick();

      // Random traffic against the shadow memory and latency/ordering rules
      bus_pend = 1'b0;
      prev_i_ack = 1'b0;
      prev_d_ack = 1'b0;
      i_gap = 0;
      d_gap = 0;
      i_bound = 4;
      d_bound = 4;
      for (int c = 0; c < 600; c++) begin
         tick();
         chk("r_busy", 64'(busy), 64'(bif.mem_en | bif.i_ack | bif.d_ack));
         chk("r_ack_excl", 64'(bif.i_ack & bif.d_ack), 64'(0));
         chk("r_ack_follows_issue", 64'(bif.i_ack | bif.d_ack), 64'(bus_pend));
         chk("r_i_twice", 64'(bif.i_ack & prev_i_ack), 64'(0));
         chk("r_d_twice", 64'(bif.d_ack & prev_d_ack), 64'(0));
         if (!bif.mem_en) begin
            chk("r_bus_idle", 64'({bif.mem_we, bif.mem_be, bif.mem_addr, bif.mem_wdata}), 64'(0));
         end
         if (bif.i_ack) begin
            chk("r_i_wait", 64'((cyc - i_start) >= 2 && (cyc - i_start) <= i_bound), 64'(1));
            chk("r_i_bus_addr", 64'(bus_addr), 64'(bif.i_addr[7:2]));
            chk("r_i_bus_cmd", 64'({bus_we, bus_be}), 64'(5'b0_1111));
            i_done();
         end
         if (bif.d_ack) begin
            chk("r_d_wait", 64'((cyc - d_start) >= 2 && (cyc - d_start) <= d_bound), 64'(1));
            chk("r_d_bus_addr", 64'(bus_addr), 64'(bif.d_addr[7:2]));
            chk("r_d_bus_we", 64'(bus_we), 64'(bif.d_we));
            if (bif.d_we) chk("r_d_bus_wr", 64'({bus_be, bus_wdata}), 64'({bif.d_be, bif.d_wdata}));
            d_done();
         end
         prev_i_ack = bif.i_ack;
         prev_d_ack = bif.d_ack;
         bus_pend   = bif.mem_en;
         bus_addr   = bif.mem_addr;
         bus_we     = bif.mem_we;
         bus_be     = bif.mem_be;
         bus_wdata  = bif.mem_wdata;

         if (bif.i_ack) begin
            if ($urandom_range(0, 2) == 0) begin new_i(); i_bound = 5; end
            else begin bif.i_req = 1'b0; i_gap = $urandom_range(0, 2); end
         end else if (!bif.i_req) begin
            if (i_gap > 0) i_gap--;
            else if ($urandom_range(0, 1) == 1) begin new_i(); i_bound = 4; end
         end
         if (bif.d_ack) begin
            if ($urandom_range(0, 2) == 0) begin new_d(); d_bound = 5; end
            else begin bif.d_req = 1'b0; d_gap = $urandom_range(0, 2); end
         end else if (!bif.d_req) begin
            if (d_gap > 0) d_gap--;
            else if ($urandom_range(0, 1) == 1) begin new_d(); d_bound = 4; end
         end
      end

      // Drain outstanding requests within a bounded number of cycles
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bif.i_ack) begin i_done(); bif.i_req = 1'b0; end
         if (bif.d_ack) begin d_done(); bif.d_req = 1'b0; end
      end
      chk("drain_reqs", 64'({bif.i_req, bif.d_req}), 64'(0));
      chk("drain_busy", 64'(busy), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
